// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] SRAM_BASE_DEFAULT = 32'd1024;
  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;

endpackage

// File: rtl/sram_controller.sv
// MEM-stage responder: serves 32-bit pipeline loads/stores from a 16-bit async SRAM
// as two half-accesses of HALF_CYCLES clocks each, holding ready low meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          HALF_CYCLES = 2,
  parameter logic [31:0] SRAM_BASE   = SRAM_BASE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output logic                   sram_ub_n,
  output logic                   sram_lb_n,
  output logic [1:0]             dbg_state
);

  // Handshake: a request (rd_en|wr_en) is taken only in IDLE; ready stays low from that
  // cycle until the one-cycle DONE pulse, and the requester must hold its stage until then.

  state_t                 r_state, w_next_state;
  logic [3:0]             r_cnt, w_next_cnt;
  logic                   r_is_wr;
  logic [16:0]            r_word;
  logic [31:0]            r_wdata;
  logic [15:0]            r_rdata_lo;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_dq_out;
  logic                   r_dq_oe, r_we_n, r_oe_n;

  logic        w_req, w_last, w_cap, w_is_wr, w_next_busy, w_unused;
  logic [31:0] w_off, w_wdata;
  logic [16:0] w_word;

  assign w_req    = rd_en | wr_en;
  assign w_off    = address - SRAM_BASE;
  assign w_unused = ^{w_off[31:19], w_off[1:0]};
  assign w_last   = (r_cnt == 4'(HALF_CYCLES - 1));
  assign w_cap    = (r_state == IDLE) && w_req;

  // SRAM outputs are registered from the next state, so values seen at capture time are muxed in.
  assign w_is_wr     = w_cap ? wr_en : r_is_wr;
  assign w_word      = w_cap ? w_off[18:2] : r_word;
  assign w_wdata     = w_cap ? write_data : r_wdata;
  assign w_next_busy = (w_next_state == LOW) || (w_next_state == HIGH);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_next_state = LOW;
        w_next_cnt   = 4'd0;
      end
      LOW: if (w_last) begin
        w_next_state = HIGH;
        w_next_cnt   = 4'd0;
      end else begin
        w_next_cnt = r_cnt + 4'd1;
      end
      HIGH: if (w_last) begin
        w_next_state = DONE;
        w_next_cnt   = 4'd0;
      end else begin
        w_next_cnt = r_cnt + 4'd1;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (r_state)
      IDLE:    ready = ~w_req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_rdata_lo  <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_cap) begin
        r_is_wr <= wr_en;
        r_word  <= w_off[18:2];
        r_wdata <= write_data;
      end
      // The low half is staged so read_data only ever changes on a completed read.
      if (!r_is_wr && w_last) begin
        if (r_state == LOW)  r_rdata_lo  <= sram_dq_in;
        if (r_state == HIGH) r_read_data <= {sram_dq_in, r_rdata_lo};
      end
      r_we_n  <= ~(w_next_busy & w_is_wr);
      r_oe_n  <= ~(w_next_busy & ~w_is_wr);
      r_dq_oe <= w_next_busy & w_is_wr;
      if (w_next_state == LOW) begin
        r_sram_addr <= {w_word, 1'b0};
        r_dq_out    <= w_wdata[15:0];
      end else if (w_next_state == HIGH) begin
        r_sram_addr <= {w_word, 1'b1};
        r_dq_out    <= w_wdata[31:16];
      end
    end
  end

  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_ce_n   = 1'b0;
  assign sram_ub_n   = 1'b0;
  assign sram_lb_n   = 1'b0;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural 256Kx16 SRAM, reference word map
// and an expected-read queue checked at each DONE pulse.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] last_rd = 32'h0;

  always #5 clk = ~clk;

  sram_controller #(.HALF_CYCLES(H), .SRAM_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .dbg_state(dbg_state)
  );

  // Behavioural SRAM: combinational read, write committed each clock while we_n is low.
  logic [15:0] sram_mem [0:(1<<18)-1];
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request on a falling edge and follows it to its DONE cycle; the request
  // is left asserted so the caller chooses between dropping it and a back-to-back access.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data);
    int          lat;
    bit          done;
    logic [31:0] exp;
    @(negedge clk);
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    if (wr) ref_mem[addr] = data;
    else    exp_q.push_back(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0);
    #1;
    check_eq("req_state_idle", 32'(dbg_state), 32'(IDLE));
    check_eq("req_ready_low", 32'(ready), 32'd0);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      done = ready;
    end
    check_eq("latency", 32'(lat), 32'(2 * H + 1));
    check_eq("done_state", 32'(dbg_state), 32'(DONE));
    if (!wr) begin
      check_eq("exp_q_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check_eq("read_data", read_data, exp);
        last_rd = exp;
      end
    end else begin
      check_eq("read_data_hold", read_data, last_rd);
    end
  endtask

  task automatic drop_req();
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < (1 << 18); i++) sram_mem[i] = 16'h0000;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_read_data", read_data, 32'h0);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("tied_low", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    drop_req();
    check_eq("w0_lo", 32'(sram_mem[0]), 32'h0000BEEF);
    check_eq("w0_hi", 32'(sram_mem[1]), 32'h0000DEAD);

    access(1'b0, 1'b1, 32'd1024, 32'h0);
    drop_req();
    check_eq("r0_lo_kept", 32'(sram_mem[0]), 32'h0000BEEF);
    check_eq("r0_hi_kept", 32'(sram_mem[1]), 32'h0000DEAD);

    access(1'b1, 1'b0, 32'd1028, 32'h12345678);
    access(1'b0, 1'b1, 32'd1028, 32'h0);
    drop_req();
    check_eq("w2_lo", 32'(sram_mem[2]), 32'h00005678);
    check_eq("w2_hi", 32'(sram_mem[3]), 32'h00001234);

    access(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5);
    drop_req();
    check_eq("both_lo", 32'(sram_mem[4]), 32'h0000A5A5);
    check_eq("both_hi", 32'(sram_mem[5]), 32'h0000A5A5);
    access(1'b0, 1'b1, 32'd1032, 32'h0);
    drop_req();

    for (int k = 0; k < 4; k++) begin
      a = 32'd1024 + 32'(4 * $urandom_range(16, 200));
      d = $urandom;
      access(1'b1, 1'b0, a, d);
      drop_req();
      access(1'b0, 1'b1, a, 32'h0);
      drop_req();
    end

    // Reset lands on the edge that would move the write into its high half.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_state", 32'(dbg_state), 32'(LOW));
    rst = 1'b1;
    wr_en = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("mid_rst_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("mid_rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check_eq("mid_rst_addr", 32'(sram_addr), 32'd0);
    check_eq("mid_rst_dq_out", 32'(sram_dq_out), 32'd0);
    check_eq("mid_rst_read_data", read_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("partial_lo", 32'(sram_mem[8]), 32'h00002222);
    check_eq("partial_hi", 32'(sram_mem[9]), 32'h00000000);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
